// File: rtl/fp_add_pkg.sv
// Shared definitions for the fp_add_32 issuer and the benches around fp_add_32.
package fp_add_pkg;

  localparam int FP_W = 32;

  // Quiet NaN returned in place of a sum when the adder never answers
  localparam logic [FP_W-1:0] FP_QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DROP = 2'd2
  } fp_add_state_e;

  typedef struct packed {
    logic [FP_W-1:0] a;
    logic [FP_W-1:0] b;
  } fp_pair_t;

  function automatic fp_pair_t make_pair(input logic [FP_W-1:0] a,
                                         input logic [FP_W-1:0] b);
    fp_pair_t p;
    p.a = a;
    p.b = b;
    return p;
  endfunction

endpackage

// File: rtl/fp_add_32_issuer_if.sv
// Bundles the operand stream, the result stream and the fp_add_32 add/ready
// handshake seen by the issuer. The master side is the issuer itself.
interface fp_add_32_issuer_if #(
  parameter int DEPTH = 4
) ();
  import fp_add_pkg::*;

  // operand stream
  logic                    in_valid;
  logic                    in_ready;
  logic [FP_W-1:0]         in_a;
  logic [FP_W-1:0]         in_b;

  // result stream
  logic                    out_valid;
  logic                    out_ready;
  logic [FP_W-1:0]         out_result;
  logic                    out_timeout;

  // queue occupancy
  logic [$clog2(DEPTH):0]  level;

  // fp_add_32 side
  logic                    add;
  logic [FP_W-1:0]         number1;
  logic [FP_W-1:0]         number2;
  logic [FP_W-1:0]         result;
  logic                    ready;

  modport master (
    input  in_valid, in_a, in_b, out_ready, result, ready,
    output in_ready, out_valid, out_result, out_timeout, level,
           add, number1, number2
  );

  modport slave (
    output in_valid, in_a, in_b, out_ready, result, ready,
    input  in_ready, out_valid, out_result, out_timeout, level,
           add, number1, number2
  );

endinterface

// File: rtl/fp_add_op_fifo.sv
// DEPTH-entry queue of operand pairs. The head entry is visible on rdata
// whenever the queue is not empty. A push while full is dropped even if a pop
// happens on the same edge, so full is a clean function of the stored level.
module fp_add_op_fifo
  import fp_add_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  fp_pair_t               wdata,
  output fp_pair_t               rdata,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  fp_pair_t      mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign level   = level_q;

  // Pointer and occupancy update; DEPTH is a power of two so pointers wrap naturally
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Pointer and level registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; contents need no reset since level gates every read
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/fp_add_32_issuer.sv
// Initiator for the fp_add_32 four-phase add/ready handshake. Operand pairs
// are queued, issued one at a time, and each sum (or a qNaN on timeout) is
// returned on the result stream in issue order.
//
// state   | meaning
// --------+----------------------------------------------------------------
// IDLE    | no operation in flight; pop when queue, adder and slot allow
// REQ     | add high with stable operands, waiting for ready (or timeout)
// DROP    | add low, waiting for ready to return low (or timeout)
module fp_add_32_issuer
  import fp_add_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  fp_add_32_issuer_if.master bus
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_CNT = CW'(TIMEOUT);

  fp_add_state_e   state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   cnt_inc;
  logic            add_q, add_d;
  logic [FP_W-1:0] number1_q, number1_d;
  logic [FP_W-1:0] number2_q, number2_d;
  logic            out_valid_q, out_valid_d;
  logic [FP_W-1:0] out_result_q, out_result_d;
  logic            out_timeout_q, out_timeout_d;

  logic            fifo_pop;
  fp_pair_t        fifo_head;
  logic [LW-1:0]   fifo_level;
  logic            fifo_full;
  logic            fifo_empty;
  logic            slot_free;

  fp_add_op_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.in_valid),
    .pop   (fifo_pop),
    .wdata (make_pair(bus.in_a, bus.in_b)),
    .rdata (fifo_head),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // The result slot can take a new capture if it is empty or being drained now
  assign slot_free = !out_valid_q || bus.out_ready;

  // Next-state, handshake and result-slot logic
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cnt_inc       = cnt_q + CW'(1);
    add_d         = add_q;
    number1_d     = number1_q;
    number2_d     = number2_q;
    out_valid_d   = out_valid_q && !bus.out_ready;
    out_result_d  = out_result_q;
    out_timeout_d = out_timeout_q;
    fifo_pop      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // ready must be seen low before a new request, closing the previous cycle
        if (!fifo_empty && !bus.ready && slot_free) begin
          fifo_pop  = 1'b1;
          number1_d = fifo_head.a;
          number2_d = fifo_head.b;
          add_d     = 1'b1;
          cnt_d     = '0;
          state_d   = ST_REQ;
        end
      end

      ST_REQ: begin
        if (bus.ready) begin
          out_result_d  = bus.result;
          out_timeout_d = 1'b0;
          out_valid_d   = 1'b1;
          add_d         = 1'b0;
          cnt_d         = '0;
          state_d       = ST_DROP;
        end else if (cnt_inc == TO_CNT) begin
          out_result_d  = FP_QNAN;
          out_timeout_d = 1'b1;
          out_valid_d   = 1'b1;
          add_d         = 1'b0;
          cnt_d         = '0;
          state_d       = ST_DROP;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      ST_DROP: begin
        // a stuck-high ready is abandoned after TIMEOUT cycles; IDLE still
        // refuses to issue until it sees ready low
        if (!bus.ready || (cnt_inc == TO_CNT)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      default: begin
        add_d   = 1'b0;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, handshake and result-slot registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      add_q         <= 1'b0;
      number1_q     <= '0;
      number2_q     <= '0;
      out_valid_q   <= 1'b0;
      out_result_q  <= '0;
      out_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      add_q         <= add_d;
      number1_q     <= number1_d;
      number2_q     <= number2_d;
      out_valid_q   <= out_valid_d;
      out_result_q  <= out_result_d;
      out_timeout_q <= out_timeout_d;
    end
  end

  assign bus.in_ready    = !fifo_full;
  assign bus.level       = fifo_level;
  assign bus.add         = add_q;
  assign bus.number1     = number1_q;
  assign bus.number2     = number2_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_result  = out_result_q;
  assign bus.out_timeout = out_timeout_q;

endmodule
